// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: hazard-unit bundle between the pipeline datapath and the hazard controller
interface ex_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] rn_D, rm_D, rn_E, rm_E, rd_E, rd_M, rd_W;
  logic usesRn_D, usesRm_D, memRead_E, regWrite_M, branchTaken_M, memAccess_M, memReady_M, regWrite_W;
  logic [1:0] forwardA_E, forwardB_E;
  logic stall_F, stall_D, stall_E, stall_M;
  logic flush_D, flush_E, flush_M, flush_W;
  logic err;
  logic [CNT_W-1:0] stallCycles, flushEvents, luEvents;
  modport master (
    output rn_D, rm_D, usesRn_D, usesRm_D, rn_E, rm_E, rd_E, memRead_E, rd_M, regWrite_M,
           branchTaken_M, memAccess_M, memReady_M, rd_W, regWrite_W,
    input  forwardA_E, forwardB_E, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M, flush_W, err, stallCycles, flushEvents, luEvents
  );
  modport slave (
    input  rn_D, rm_D, usesRn_D, usesRm_D, rn_E, rm_E, rd_E, memRead_E, rd_M, regWrite_M,
           branchTaken_M, memAccess_M, memReady_M, rd_W, regWrite_W,
    output forwardA_E, forwardB_E, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M, flush_W, err, stallCycles, flushEvents, luEvents
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: LEGv8 forwarding, load-use, branch-flush and memory-wait control with event counters
module ex_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic reset,
  ex_hazard_ctrl_if.slave h
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic mem_wait, load_use, halt, br, lu;
  assign h.forwardA_E = (h.regWrite_M && h.rd_M != 5'd31 && h.rd_M == h.rn_E) ? 2'b10 :
                        (h.regWrite_W && h.rd_W != 5'd31 && h.rd_W == h.rn_E) ? 2'b01 : 2'b00;
  assign h.forwardB_E = (h.regWrite_M && h.rd_M != 5'd31 && h.rd_M == h.rm_E) ? 2'b10 :
                        (h.regWrite_W && h.rd_W != 5'd31 && h.rd_W == h.rm_E) ? 2'b01 : 2'b00;
  always_comb begin
    mem_wait  = h.memAccess_M && !h.memReady_M;
    load_use  = h.memRead_E && h.rd_E != 5'd31 &&
                ((h.usesRn_D && h.rn_D == h.rd_E) || (h.usesRm_D && h.rm_D == h.rd_E));
    // a reset cycle behaves as RUN, so ERROR is masked while reset is high
    h.err     = state == ERROR && !reset;
    halt      = h.err || mem_wait;
    br        = !halt && h.branchTaken_M;
    lu        = !halt && !h.branchTaken_M && load_use;
    h.stall_F = halt || lu;
    h.stall_D = halt || lu;
    h.stall_E = halt;
    h.stall_M = halt;
    h.flush_D = br;
    h.flush_E = br || lu;
    h.flush_M = br;
    h.flush_W = halt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      wait_cnt      <= '0;
      h.stallCycles <= '0;
      h.flushEvents <= '0;
      h.luEvents    <= '0;
    end else begin
      if (h.stall_F && h.stallCycles != '1) h.stallCycles <= h.stallCycles + 1'b1;
      if (br && h.flushEvents != '1) h.flushEvents <= h.flushEvents + 1'b1;
      if (lu && h.luEvents != '1) h.luEvents <= h.luEvents + 1'b1;
      case (state)
        RUN: if (mem_wait) begin
          state    <= MEM_WAIT;
          wait_cnt <= WW'(1);
        end
        MEM_WAIT: if (!mem_wait) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) state <= ERROR;
        else wait_cnt <= wait_cnt + 1'b1;
        default: state <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: randomized + directed scoreboard bench against a behavioural hazard model
module tb_ex_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;
  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;
  ex_hazard_ctrl_if #(.CNT_W(CW)) hif ();
  ex_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .h(hif.slave));

  typedef struct {
    logic rst;
    logic [4:0] rn_d, rm_d, rn_e, rm_e, rd_e, rd_m, rd_w;
    logic urn, urm, mr_e, rw_m, br_m, ma_m, rdy_m, rw_w;
  } stim_t;
  typedef struct {
    string tag;
    logic [1:0] fa, fb;
    logic [3:0] stall, flush;
    logic err;
    logic [CW-1:0] sc, fe, lu;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int md = 0, wc = 0;
  int sc = 0, fe = 0, lu = 0;
  localparam int SAT = (1 << CW) - 1;

  function automatic logic [1:0] fwd(stim_t s, logic [4:0] r);
    if (s.rw_m && s.rd_m != 31 && s.rd_m == r) return 2'b10;
    if (s.rw_w && s.rd_w != 31 && s.rd_w == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model(input stim_t s, input string tag);
    exp_t e;
    int m;
    bit mw, ldu, c2, c3;
    m   = s.rst ? 0 : md;
    mw  = s.ma_m && !s.rdy_m;
    ldu = s.mr_e && s.rd_e != 31 && ((s.urn && s.rn_d == s.rd_e) || (s.urm && s.rm_d == s.rd_e));
    e.tag = tag;
    e.fa = fwd(s, s.rn_e);
    e.fb = fwd(s, s.rm_e);
    e.stall = 4'b0000; e.flush = 4'b0000;
    c2 = 0; c3 = 0;
    if (m == 2 || mw) begin e.stall = 4'b1111; e.flush = 4'b0001; end
    else if (s.br_m) begin e.flush = 4'b1110; c2 = 1; end
    else if (ldu) begin e.stall = 4'b1100; e.flush = 4'b0100; c3 = 1; end
    e.err = (m == 2);
    e.sc = CW'(sc); e.fe = CW'(fe); e.lu = CW'(lu);
    q.push_back(e);
    if (s.rst) begin
      md = 0; wc = 0; sc = 0; fe = 0; lu = 0;
    end else begin
      if (e.stall[3] && sc < SAT) sc++;
      if (c2 && fe < SAT) fe++;
      if (c3 && lu < SAT) lu++;
      if (md == 0 && mw) begin md = 1; wc = 1; end
      else if (md == 1) begin
        if (!mw) begin md = 0; wc = 0; end
        else if (wc >= TO - 1) md = 2;
        else wc++;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst;
    hif.rn_D = s.rn_d; hif.rm_D = s.rm_d; hif.usesRn_D = s.urn; hif.usesRm_D = s.urm;
    hif.rn_E = s.rn_e; hif.rm_E = s.rm_e; hif.rd_E = s.rd_e; hif.memRead_E = s.mr_e;
    hif.rd_M = s.rd_m; hif.regWrite_M = s.rw_m; hif.branchTaken_M = s.br_m;
    hif.memAccess_M = s.ma_m; hif.memReady_M = s.rdy_m;
    hif.rd_W = s.rd_w; hif.regWrite_W = s.rw_w;
  endtask

  task automatic step(input stim_t s, input string tag);
    @(posedge clk); #1;
    apply(s);
    model(s, tag);
  endtask

  task automatic chk(input string n, input exp_t e, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s.%s got=%0h exp=%0h", e.tag, n, a, x);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwdA", e, 32'(hif.forwardA_E), 32'(e.fa));
        chk("fwdB", e, 32'(hif.forwardB_E), 32'(e.fb));
        chk("stall", e, 32'({hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M}), 32'(e.stall));
        chk("flush", e, 32'({hif.flush_D, hif.flush_E, hif.flush_M, hif.flush_W}), 32'(e.flush));
        chk("err", e, 32'(hif.err), 32'(e.err));
        chk("stallCycles", e, 32'(hif.stallCycles), 32'(e.sc));
        chk("flushEvents", e, 32'(hif.flushEvents), 32'(e.fe));
        chk("luEvents", e, 32'(hif.luEvents), 32'(e.lu));
      end
    end
  end

  function automatic logic [4:0] rreg();
    int r = $urandom_range(0, 5);
    return (r == 5) ? 5'd31 : 5'(r);
  endfunction

  initial begin : driver
    stim_t z, s;
    z = '{rst: 0, rn_d: 0, rm_d: 0, rn_e: 0, rm_e: 0, rd_e: 0, rd_m: 0, rd_w: 0,
          urn: 0, urm: 0, mr_e: 0, rw_m: 0, br_m: 0, ma_m: 0, rdy_m: 0, rw_w: 0};
    s = z; s.rst = 1;
    apply(s);
    repeat (2) @(posedge clk);
    #1; apply(z);
    step(z, "reset_state");
    s = z; s.rn_e = 3; s.rd_m = 3; s.rw_m = 1; s.rd_w = 3; s.rw_w = 1; step(s, "fwd_mem");
    s.rw_m = 0; step(s, "fwd_wb");
    s.rw_m = 1; s.rd_m = 31; s.rd_w = 31; s.rn_e = 31; s.rm_e = 31; step(s, "fwd_xzr");
    s = z; s.rm_e = 7; s.rd_m = 7; s.rw_m = 1; s.rd_w = 7; s.rw_w = 1; step(s, "fwdB_mem");
    s = z; s.mr_e = 1; s.rd_e = 5; s.urm = 1; s.rm_d = 5; step(s, "load_use");
    step(z, "lu_release");
    s.rd_e = 31; s.rm_d = 31; step(s, "lu_xzr");
    s = z; s.mr_e = 1; s.rd_e = 5; s.urm = 1; s.rm_d = 5; s.br_m = 1; step(s, "br_over_lu");
    step(z, "br_after");
    s = z; s.ma_m = 1; s.rdy_m = 0;
    repeat (3) step(s, "mem_wait");
    s.rdy_m = 1; step(s, "mem_ready");
    step(z, "mem_run");
    s = z; s.ma_m = 1; s.rdy_m = 0;
    repeat (4) step(s, "timeout_wait");
    s.br_m = 1; s.mr_e = 1; s.rd_e = 2; s.urn = 1; s.rn_d = 2;
    repeat (3) step(s, "error_hold");
    step(z, "error_idle");
    s = z; s.rst = 1; step(s, "reset_error");
    step(z, "after_reset");
    s = z; s.ma_m = 1;
    repeat (2) step(s, "wait_pre_reset");
    s.rst = 1; step(s, "reset_mid_wait");
    s.rst = 0; s.rdy_m = 1; step(s, "after_mid_reset");
    for (int i = 0; i < 1500; i++) begin
      s.rst = ($urandom_range(0, 99) < 2);
      s.rn_d = rreg(); s.rm_d = rreg(); s.rn_e = rreg(); s.rm_e = rreg();
      s.rd_e = rreg(); s.rd_m = rreg(); s.rd_w = rreg();
      s.urn = 1'($urandom); s.urm = 1'($urandom); s.mr_e = 1'($urandom);
      s.rw_m = 1'($urandom); s.rw_w = 1'($urandom);
      s.br_m = ($urandom_range(0, 99) < 15);
      s.ma_m = ($urandom_range(0, 99) < 25);
      s.rdy_m = ($urandom_range(0, 99) < 40);
      step(s, "random");
    end
    s = z; s.ma_m = 1;
    repeat (300) step(s, "saturate");
    s = z; s.rst = 1; step(s, "final_reset");
    step(z, "final_idle");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
